// File: rtl/mini_alu_core_p.sv
// mini_alu_core_p: two-stage (decode/execute) parametrised MiniAlu core with a
// bypassed register file and a return stack. Define MINI_ALU_FAULT_HALT_EN to halt on stack faults.
module mini_alu_core_p #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned RF_DEPTH    = 256,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned VGA_COLS    = 100
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] oIP,
  input  logic [27:0]           iInstruction,
  output logic [7:0]            oLed,
  output logic                  oVgaWe,
  output logic [15:0]           oVgaAddr,
  output logic [2:0]            oVgaColor,
  output logic                  oStackFault,
  output logic                  oHalted
);
  localparam int unsigned RIDX_W  = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
  localparam int unsigned SP_W    = $clog2(STACK_DEPTH + 1);
  localparam int unsigned STK_ENT = 1 << SP_W;
  localparam logic [27:0] NOP_INSTR = 28'h0;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SMUL = 4'd3;
  localparam logic [3:0] OP_STO  = 4'd4;
  localparam logic [3:0] OP_BLE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_CALL = 4'd8;
  localparam logic [3:0] OP_RET  = 4'd9;
  localparam logic [3:0] OP_LED  = 4'd10;
  localparam logic [3:0] OP_VGA  = 4'd11;

  logic [ADDR_WIDTH-1:0] pc_q, pc_n, ex_pc_q, ex_pc_n;
  logic [27:0]           ex_instr_q, ex_instr_n;
  logic [DATA_WIDTH-1:0] ex_s1_q, ex_s1_n, ex_s0_q, ex_s0_n;
  logic [SP_W-1:0]       sp_q, sp_n;
  logic [7:0]            led_q, led_n;
  logic                  vga_we_q, vga_we_n;
  logic [15:0]           vga_addr_q, vga_addr_n;
  logic [2:0]            vga_color_q, vga_color_n;
  logic                  fault_q, fault_n, halted_q, halted_n;

  logic [DATA_WIDTH-1:0] rf_q [RF_DEPTH];
  logic [ADDR_WIDTH-1:0] stack_q [STK_ENT];

  logic [3:0]            ex_op;
  logic [7:0]            ex_dest, ex_f1, ex_f0;
  logic signed [15:0]    sto_imm;
  logic                  wr_en, take, push, pop, fault_now, stall;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [RIDX_W-1:0]     wr_idx, rd1_idx, rd0_idx;
  logic [ADDR_WIDTH-1:0] target;

  assign {ex_op, ex_dest, ex_f1, ex_f0} = ex_instr_q;
  assign sto_imm = {ex_f1, ex_f0};
  assign wr_idx  = ex_dest[RIDX_W-1:0];
  assign rd1_idx = iInstruction[8 +: RIDX_W];
  assign rd0_idx = iInstruction[0 +: RIDX_W];

  // Execute stage: ALU result, branch resolution, stack and output effects.
  always_comb begin
    wr_en       = 1'b0;
    wr_data     = '0;
    take        = 1'b0;
    target      = ADDR_WIDTH'(ex_dest);
    push        = 1'b0;
    pop         = 1'b0;
    fault_now   = 1'b0;
    led_n       = led_q;
    vga_we_n    = 1'b0;
    vga_addr_n  = vga_addr_q;
    vga_color_n = vga_color_q;
    case (ex_op)
      OP_ADD:  begin wr_en = 1'b1; wr_data = ex_s1_q + ex_s0_q; end
      OP_SUB:  begin wr_en = 1'b1; wr_data = ex_s1_q - ex_s0_q; end
      OP_SMUL: begin wr_en = 1'b1; wr_data = DATA_WIDTH'($signed(ex_s1_q) * $signed(ex_s0_q)); end
      OP_STO:  begin wr_en = 1'b1; wr_data = DATA_WIDTH'(sto_imm); end
      OP_BLE:  take = ($signed(ex_s1_q) <= $signed(ex_s0_q));
      OP_JMP:  take = 1'b1;
      OP_SHL:  begin wr_en = 1'b1; wr_data = ex_s1_q << ex_f0; end
      OP_CALL: begin
        if (sp_q == SP_W'(STACK_DEPTH)) fault_now = 1'b1;
        else begin push = 1'b1; take = 1'b1; end
      end
      OP_RET: begin
        if (sp_q == '0) fault_now = 1'b1;
        else begin
          pop    = 1'b1;
          take   = 1'b1;
          target = stack_q[sp_q - SP_W'(1)];
        end
      end
      OP_LED:  led_n = ex_s1_q[7:0];
      OP_VGA: begin
        vga_we_n    = 1'b1;
        vga_addr_n  = 16'(ex_s1_q) * 16'(VGA_COLS) + 16'(ex_s0_q);
        vga_color_n = ex_dest[2:0];
      end
      default: ;
    endcase
  end

  // Fetch/decode next state; a taken branch or halt squashes the captured instruction.
  always_comb begin
`ifdef MINI_ALU_FAULT_HALT_EN
    stall    = halted_q | fault_now;
    halted_n = stall;
`else
    stall    = 1'b0;
    halted_n = 1'b0;
`endif
    pc_n       = pc_q + ADDR_WIDTH'(1);
    ex_instr_n = iInstruction;
    ex_pc_n    = pc_q;
    ex_s1_n    = (wr_en && wr_idx == rd1_idx) ? wr_data : rf_q[rd1_idx];
    ex_s0_n    = (wr_en && wr_idx == rd0_idx) ? wr_data : rf_q[rd0_idx];
    sp_n       = sp_q;
    fault_n    = fault_q | fault_now;
    if (stall) pc_n = pc_q;
    else if (take) pc_n = target;
    if (stall || take) ex_instr_n = NOP_INSTR;
    if (push) sp_n = sp_q + SP_W'(1);
    else if (pop) sp_n = sp_q - SP_W'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q        <= '0;
      ex_instr_q  <= NOP_INSTR;
      ex_pc_q     <= '0;
      ex_s1_q     <= '0;
      ex_s0_q     <= '0;
      sp_q        <= '0;
      led_q       <= '0;
      vga_we_q    <= 1'b0;
      vga_addr_q  <= '0;
      vga_color_q <= '0;
      fault_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_n;
      ex_instr_q  <= ex_instr_n;
      ex_pc_q     <= ex_pc_n;
      ex_s1_q     <= ex_s1_n;
      ex_s0_q     <= ex_s0_n;
      sp_q        <= sp_n;
      led_q       <= led_n;
      vga_we_q    <= vga_we_n;
      vga_addr_q  <= vga_addr_n;
      vga_color_q <= vga_color_n;
      fault_q     <= fault_n;
      halted_q    <= halted_n;
    end
  end

  // Storage arrays are not reset; reset only blocks new writes.
  always_ff @(posedge Clock) begin
    if (!Reset && wr_en) rf_q[wr_idx] <= wr_data;
    if (!Reset && push) stack_q[sp_q] <= ex_pc_q + ADDR_WIDTH'(1);
  end

  assign oIP         = pc_q;
  assign oLed        = led_q;
  assign oVgaWe      = vga_we_q;
  assign oVgaAddr    = vga_addr_q;
  assign oVgaColor   = vga_color_q;
  assign oStackFault = fault_q;
  assign oHalted     = halted_q;
endmodule

// File: doc/mini_alu_core_p.md
Name: mini_alu_core_p

Overview:
Parametrised successor of the MiniAlu datapath: a two-stage (decode, execute) in-order core fetching 28-bit instructions from an external asynchronous ROM. It adds an internal register file with write-to-read bypass, a multi-level return stack for nested CALL/RET, generic data width, and a stack-fault flag. It sits between InstructionRom and VideoMemory/LED flops in the top level.

Parameters:
DATA_WIDTH, 16, register/ALU width in bits (8..32)
ADDR_WIDTH, 16, instruction address width (8..16)
RF_DEPTH, 256, number of registers (power of 2, <=256; register index = field[log2(RF_DEPTH)-1:0])
STACK_DEPTH, 4, return-stack entries (1..16)
VGA_COLS, 100, row stride for VGA address

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous active-high reset
oIP  out  ADDR_WIDTH  fetch address to ROM
iInstruction  in  28  ROM data for oIP, same cycle; [27:24] op, [23:16] dest, [15:8] src1, [7:0] src0
oLed  out  8  LED register
oVgaWe  out  1  one-cycle video write strobe
oVgaAddr  out  16  src1Data*VGA_COLS+src0Data, low 16 bits
oVgaColor  out  3  dest[2:0]
oStackFault  out  1  sticky: overflow/underflow seen
oHalted  out  1  core halted (see optional feature)

Behaviour:
- Reset (sync, priority over all): PC=0, decode/exec regs = NOP, stack pointer=0, oLed=0, oVgaWe=0, oStackFault=0, oHalted=0. Register file contents not reset.
- Decode edge: capture iInstruction, PC of that instruction, and operand data RF[src1], RF[src0]. Bypass: if exec stage writes register R on the same edge, captured operand for R = write data.
- PC <= PC+1 each cycle, wraps at 2^ADDR_WIDTH. Branch taken in exec: PC <= zero-extended dest field; instruction captured on that edge replaced by NOP (exactly one bubble).
- Opcodes (exec stage): 0 NOP; 1 ADD d=s1+s0; 2 SUB d=s1-s0; 3 SMUL d=low DATA_WIDTH of signed s1*s0; 4 STO d={src1,src0} fields truncated/sign-extended to DATA_WIDTH; 5 BLE branch if signed s1<=s0; 6 JMP; 7 SHL d=s1<<src0 field (literal, shift >=DATA_WIDTH gives 0); 8 CALL push exec PC+1, branch; 9 RET pop, PC <= popped value, one bubble; 10 LED oLed<=s1[7:0] next edge; 11 VGA oVgaWe=1 for one cycle with oVgaAddr/oVgaColor valid same cycle; 12..15 NOP.
- All arithmetic wraps modulo 2^DATA_WIDTH. Writes commit at end of exec cycle.
- Stack: CALL when full -> not taken (NOP), oStackFault<=1. RET when empty -> not taken, oStackFault<=1. Nested depth up to STACK_DEPTH exact.
- oVgaWe, oLed change only via their opcodes; oStackFault clears only on Reset.

Optional Feature:
MINI_ALU_FAULT_HALT_EN: defined -> on stack fault, oHalted<=1 same edge; PC frozen, decode fed NOPs, no RF/LED/VGA writes until Reset. Undefined -> oHalted tied 0, execution continues after fault.

Test Plan:
STO r1=5; STO r2=7; ADD r3=r2+r1 back-to-back; LED r3 -> oLed=0x0C (bypass exercised, no stall).
STO r1=3; STO r2=3; BLE to 0x20 -> oIP=0x20 two cycles after BLE enters exec; instruction after BLE not executed (its LED does not fire).
CALL 0x10 at 0x02, CALL 0x20 in sub, RET, RET -> oIP returns 0x11 path then 0x03; oStackFault=0.
STACK_DEPTH=2: three nested CALLs -> third not taken, oStackFault=1; with MINI_ALU_FAULT_HALT_EN oHalted=1, oIP frozen.
STO r1=2, r2=3, VGA dest=5 -> oVgaWe pulse 1 cycle, oVgaAddr=302, oVgaColor=5.
Reset asserted mid-loop -> next cycle oIP=0, oLed=0, oStackFault=0; RET with empty stack after reset sets fault.
